full_subtractor_1bit: RTL and testbench
=======================================

// Module: full_subtractor_1bit
// PURPOSE
//  Registered 1-bit full subtractor: computes A - B - borrow_in -> {borrow_out, diff}.
//  Used as the leaf cell of ripple-borrow subtractors and as a standalone arithmetic check cell.
//  Carries a valid qualifier through a configurable register pipeline.
//  Single clock; synchronous, active-high reset.
// PARAMETERS
//  LATENCY   1   output register stages, 0..4; 0 = purely combinational path (reset has no effect on data)
// PORTS
//  clk         in   1  clock, all state updates on rising edge
//  reset       in   1  synchronous active-high reset
//  A           in   1  minuend bit
//  B           in   1  subtrahend bit
//  borrow_in   in   1  borrow from the less significant stage
//  in_valid    in   1  A/B/borrow_in are meaningful this cycle
//  diff        out  1  difference bit
//  borrow_out  out  1  borrow to the more significant stage
//  out_valid   out  1  diff/borrow_out are meaningful this cycle
// BEHAVIOUR
//  - diff = A ^ B ^ borrow_in
//  - borrow_out = (~A & (B | borrow_in)) | (B & borrow_in)
//  - Truth table {A,B,bin} -> {diff,bout}: 000->00, 001->11, 010->11, 011->01,
//    100->10, 101->00, 110->00, 111->11
//  - LATENCY=N>0: the result of the inputs sampled at edge k is on the outputs after edge k+N-1;
//    out_valid follows in_valid with the same delay; a new operand is accepted every cycle (no stall).
//  - Data stages load unconditionally (in_valid only qualifies); consumers ignore data when out_valid=0.
//  - Reset (LATENCY>0): diff=0, borrow_out=0, out_valid=0 on the clock edge where reset=1;
//    all pipeline stages flushed. Reset mid-stream drops every in-flight result; the first valid
//    input after reset deasserts appears N cycles later.
//  - LATENCY=0: outputs follow inputs combinationally; out_valid = in_valid.
//  - Any X/Z input propagates; no input sanitising.
// CONFIGURATION
//  Macro FULL_SUBTRACTOR_BORROW_CNT_EN:
//   defined -> extra ports: cnt_clr in 1 (sync clear), borrow_cnt out 8. borrow_cnt increments by 1
//     on each cycle with out_valid=1 and borrow_out=1, saturates at 255, resets to 0 on reset or
//     cnt_clr (clear wins over a simultaneous increment).
//   undefined -> ports and counter absent; core behaviour identical.
// STRUCTURE
//  - Package fs_pkg: localparam FS_MAX_LATENCY=4, FS_CNT_W=8, typedef struct {diff, borrow, valid} fs_result_t.
//  - Sub-module fs_core_comb: pure combinational diff/borrow equations; top instantiates it
//    and wraps it in the LATENCY-deep register pipeline (generate loop) plus optional counter.
//  - Elaboration error if LATENCY > FS_MAX_LATENCY.
// TESTING
//  1. Exhaustive: drive all 8 {A,B,borrow_in} combos with in_valid=1, one per cycle -> outputs
//     match the truth table exactly LATENCY cycles later, out_valid=1 throughout.
//  2. Reset: run 4 valid ops, assert reset 1 cycle -> next edge diff=0, borrow_out=0, out_valid=0;
//     no pre-reset result ever emerges.
//  3. Bubbles: in_valid pattern 1,0,1,0 with A=1,B=0,bin=0 -> out_valid 1,0,1,0 delayed by LATENCY, diff=1 on valid cycles.
//  4. LATENCY=0 build: A=0,B=1,bin=1 -> same cycle diff=0, borrow_out=1.
//  5. Counter (macro on): 300 valid ops of {0,1,0} -> borrow_cnt saturates at 255; cnt_clr -> 0.
//  6. Ripple check: chain 4 instances (LATENCY=0), 4'b0011 - 4'b0101 -> 4'b1110, final borrow_out=1.

Source files
------------

// File: rtl/fs_pkg.sv
// Shared constants and result record for the registered 1-bit full subtractor.
package fs_pkg;

    localparam int unsigned FS_MAX_LATENCY = 4;
    localparam int unsigned FS_CNT_W       = 8;

    typedef struct packed {
        logic diff;
        logic borrow;
        logic valid;
    } fs_result_t;

endpackage

// File: rtl/fs_core_comb.sv
// Combinational full-subtractor equations: {o_borrow, o_diff} = i_a - i_b - i_borrow.
module fs_core_comb (
    input  logic i_a,
    input  logic i_b,
    input  logic i_borrow,
    output logic o_diff,
    output logic o_borrow
);

    assign o_diff   = i_a ^ i_b ^ i_borrow;
    assign o_borrow = (~i_a & (i_b | i_borrow)) | (i_b & i_borrow);

endmodule

// File: rtl/full_subtractor_1bit.sv
// Registered 1-bit full subtractor with a LATENCY-deep valid-qualified pipeline.
// Optional saturating borrow counter enabled by FULL_SUBTRACTOR_BORROW_CNT_EN.
module full_subtractor_1bit
    import fs_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                A,
    input  logic                B,
    input  logic                borrow_in,
    input  logic                in_valid,
    output logic                diff,
    output logic                borrow_out,
    output logic                out_valid
`ifdef FULL_SUBTRACTOR_BORROW_CNT_EN
    ,
    input  logic                cnt_clr,
    output logic [FS_CNT_W-1:0] borrow_cnt
`endif
);

    if (LATENCY > FS_MAX_LATENCY) begin : g_lat_check
        $error("full_subtractor_1bit: LATENCY exceeds FS_MAX_LATENCY");
    end

    logic       w_diff;
    logic       w_borrow;
    fs_result_t w_stage [0:LATENCY];

    fs_core_comb u_core (
        .i_a      (A),
        .i_b      (B),
        .i_borrow (borrow_in),
        .o_diff   (w_diff),
        .o_borrow (w_borrow)
    );

    assign w_stage[0] = '{diff: w_diff, borrow: w_borrow, valid: in_valid};

    // Data loads unconditionally; valid only qualifies. Reset flushes every stage.
    for (genvar i = 0; i < LATENCY; i++) begin : g_stage
        fs_result_t r_stage;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_stage <= '0;
            end else begin
                r_stage <= w_stage[i];
            end
        end

        assign w_stage[i+1] = r_stage;
    end

    assign diff       = w_stage[LATENCY].diff;
    assign borrow_out = w_stage[LATENCY].borrow;
    assign out_valid  = w_stage[LATENCY].valid;

`ifdef FULL_SUBTRACTOR_BORROW_CNT_EN
    logic [FS_CNT_W-1:0] r_cnt;

    // Clear wins over a simultaneous increment; counter holds at all-ones.
    always_ff @(posedge clk) begin
        if (reset || cnt_clr) begin
            r_cnt <= '0;
        end else if (out_valid && borrow_out && (r_cnt != {FS_CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign borrow_cnt = r_cnt;
`endif

endmodule

// File: tb/tb_full_subtractor_1bit.sv
// Self-checking bench: table-driven vectors through a scoreboard queue, plus reset,
// bubble, combinational and ripple-chain sequences.
module tb_full_subtractor_1bit;

    localparam int unsigned LAT = 2;

    typedef struct {
        logic a;
        logic b;
        logic bin;
        logic diff;
        logic bout;
    } vec_t;

    typedef struct {
        logic diff;
        logic bout;
        logic valid;
        logic chk;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic a, b, bin, iv;
    logic diff, bout, ov;
    logic c_a, c_b, c_bin, c_iv;
    logic c_diff, c_bout, c_ov;
    logic [3:0] r_a, r_b;
    logic       r_bin0;
    wire  [4:0] w_bc;
    wire  [3:0] w_rd;
    wire  [3:0] w_rv;

    vec_t vecs [8];
    exp_t sb [$];
    int   total = 0;
    int   bad   = 0;

`ifdef FULL_SUBTRACTOR_BORROW_CNT_EN
    logic       cnt_clr;
    logic [7:0] borrow_cnt;
    logic [7:0] c_cnt;
    wire  [7:0] w_rcnt [4];
`endif

    always #5 clk = ~clk;

    full_subtractor_1bit #(.LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .A          (a),
        .B          (b),
        .borrow_in  (bin),
        .in_valid   (iv),
        .diff       (diff),
        .borrow_out (bout),
        .out_valid  (ov)
`ifdef FULL_SUBTRACTOR_BORROW_CNT_EN
        ,
        .cnt_clr    (cnt_clr),
        .borrow_cnt (borrow_cnt)
`endif
    );

    full_subtractor_1bit #(.LATENCY(0)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .A          (c_a),
        .B          (c_b),
        .borrow_in  (c_bin),
        .in_valid   (c_iv),
        .diff       (c_diff),
        .borrow_out (c_bout),
        .out_valid  (c_ov)
`ifdef FULL_SUBTRACTOR_BORROW_CNT_EN
        ,
        .cnt_clr    (1'b0),
        .borrow_cnt (c_cnt)
`endif
    );

    assign w_bc[0] = r_bin0;

    for (genvar i = 0; i < 4; i++) begin : g_chain
        full_subtractor_1bit #(.LATENCY(0)) u_bit (
            .clk        (clk),
            .reset      (reset),
            .A          (r_a[i]),
            .B          (r_b[i]),
            .borrow_in  (w_bc[i]),
            .in_valid   (1'b1),
            .diff       (w_rd[i]),
            .borrow_out (w_bc[i+1]),
            .out_valid  (w_rv[i])
`ifdef FULL_SUBTRACTOR_BORROW_CNT_EN
            ,
            .cnt_clr    (1'b0),
            .borrow_cnt (w_rcnt[i])
`endif
        );
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic prefill();
        sb.delete();
        for (int i = 0; i < int'(LAT) - 1; i++) sb.push_back('{1'b0, 1'b0, 1'b0, 1'b1});
    endtask

    // One cycle: drive, push expectation, clock, compare the oldest expectation.
    task automatic step(input logic ta, input logic tb, input logic tbin, input logic tv);
        exp_t e;
        vec_t v;
        a = ta; b = tb; bin = tbin; iv = tv;
        v = vecs[{ta, tb, tbin}];
        sb.push_back('{v.diff, v.bout, tv, tv});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("out_valid", {7'd0, ov}, {7'd0, e.valid});
        if (e.chk) begin
            check("diff", {7'd0, diff}, {7'd0, e.diff});
            check("borrow_out", {7'd0, bout}, {7'd0, e.bout});
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        a = 1'b0; b = 1'b1; bin = 1'b1; iv = 1'b1;
        @(posedge clk);
        #1;
        check("rst_diff", {7'd0, diff}, 8'd0);
        check("rst_borrow", {7'd0, bout}, 8'd0);
        check("rst_valid", {7'd0, ov}, 8'd0);
        reset = 1'b0;
        prefill();
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        reset = 1'b1;
        a = 1'b0; b = 1'b0; bin = 1'b0; iv = 1'b0;
        c_a = 1'b0; c_b = 1'b0; c_bin = 1'b0; c_iv = 1'b0;
        r_a = 4'd0; r_b = 4'd0; r_bin0 = 1'b0;
`ifdef FULL_SUBTRACTOR_BORROW_CNT_EN
        cnt_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        do_reset();

        // Exhaustive truth table, back to back.
        for (int i = 0; i < 8; i++) step(vecs[i].a, vecs[i].b, vecs[i].bin, 1'b1);
        for (int i = 0; i < int'(LAT); i++) step(1'b0, 1'b0, 1'b0, 1'b0);

        // Mid-stream reset drops in-flight results.
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        do_reset();
        for (int i = 0; i < int'(LAT) + 1; i++) step(1'b0, 1'b0, 1'b0, 1'b0);

        // Bubbles.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, (i % 2) == 0);
        for (int i = 0; i < int'(LAT); i++) step(1'b0, 1'b0, 1'b0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        // Combinational instance ignores reset and follows inputs.
        reset = 1'b1;
        c_a = 1'b0; c_b = 1'b1; c_bin = 1'b1; c_iv = 1'b1;
        #1;
        check("l0_diff", {7'd0, c_diff}, 8'd0);
        check("l0_borrow", {7'd0, c_bout}, 8'd1);
        check("l0_valid", {7'd0, c_ov}, 8'd1);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            c_a = vecs[i].a; c_b = vecs[i].b; c_bin = vecs[i].bin; c_iv = 1'(i % 2);
            #1;
            check("l0_tt", {5'd0, c_diff, c_bout, c_ov}, {5'd0, vecs[i].diff, vecs[i].bout, 1'(i % 2)});
        end

        // Ripple-borrow chain.
        r_a = 4'b0011; r_b = 4'b0101; r_bin0 = 1'b0;
        #1;
        check("ripple_diff", {4'd0, w_rd}, 8'h0e);
        check("ripple_borrow", {7'd0, w_bc[4]}, 8'd1);
        check("ripple_valid", {4'd0, w_rv}, 8'h0f);
        r_a = 4'b1000; r_b = 4'b0001; r_bin0 = 1'b0;
        #1;
        check("ripple2_diff", {4'd0, w_rd}, 8'h07);
        check("ripple2_borrow", {7'd0, w_bc[4]}, 8'd0);

`ifdef FULL_SUBTRACTOR_BORROW_CNT_EN
        @(negedge clk);
        a = 1'b0; b = 1'b1; bin = 1'b0; iv = 1'b1;
        cnt_clr = 1'b1;
        repeat (int'(LAT) + 1) @(posedge clk);
        #1;
        check("cnt_clr", borrow_cnt, 8'd0);
        cnt_clr = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        check("cnt_sat", borrow_cnt, 8'd255);
        cnt_clr = 1'b1;
        @(posedge clk);
        #1;
        check("cnt_clr2", borrow_cnt, 8'd0);
        cnt_clr = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
